// File: rtl/shift_pkg.sv
// Shared widths and shift-op encodings for the shifter arbiter and its users.
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned IDX_W   = 3;

  typedef struct packed {
    logic right;
    logic arith;
  } shift_op_t;

  localparam shift_op_t SHIFT_SLL = '{right: 1'b0, arith: 1'b0};
  localparam shift_op_t SHIFT_SRL = '{right: 1'b1, arith: 1'b0};
  localparam shift_op_t SHIFT_SRA = '{right: 1'b1, arith: 1'b1};

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick
  import shift_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Two passes: indices >= ptr first, then the wrapped-around ones below ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && (i >= int'(ptr)) && eligible[i]) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && (i < int'(ptr)) && eligible[i]) begin
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one combinational barrel shifter among NREQ requesters,
// with a one-entry response buffer per requester.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DATA_W-1:0]  req_d,
  input  logic [NREQ*SHAMT_W-1:0] req_sa,
  input  logic [NREQ-1:0]         req_right,
  input  logic [NREQ-1:0]         req_arith,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  input  logic [NREQ-1:0]         flush,
  output logic [DATA_W-1:0]       sh_d,
  output logic [SHAMT_W-1:0]      sh_sa,
  output logic                    sh_right,
  output logic                    sh_arith,
  input  logic [DATA_W-1:0]       sh_res,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [NREQ*DATA_W-1:0]  resp_data,
  output logic [NREQ*TAG_W-1:0]   resp_tag,
  output logic [IDX_W-1:0]        grant_idx
);

  logic [DATA_W-1:0]  d_arr   [NREQ];
  logic [SHAMT_W-1:0] sa_arr  [NREQ];
  logic [TAG_W-1:0]   tag_arr [NREQ];
  shift_op_t          op_arr  [NREQ];

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] rr_ptr_q;
  shift_op_t        sh_op;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign d_arr[gi]   = req_d[gi*DATA_W +: DATA_W];
    assign sa_arr[gi]  = req_sa[gi*SHAMT_W +: SHAMT_W];
    assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
    assign op_arr[gi]  = '{right: req_right[gi], arith: req_arith[gi]};
  end

  // A full slot being drained this cycle counts as free; reset masks all issue.
  assign eligible = req_valid & ~flush & (~resp_valid | resp_ready) & {NREQ{~rst}};

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .eligible(eligible),
    .ptr     (rr_ptr_q),
    .grant   (grant),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  assign req_ready = grant;
  assign grant_idx = pick_idx;

  // AND-OR mux keeps the shifter inputs at zero when nothing is granted.
  always_comb begin
    sh_d  = '0;
    sh_sa = '0;
    sh_op = SHIFT_SLL;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sh_d  = sh_d | d_arr[i];
        sh_sa = sh_sa | sa_arr[i];
        sh_op = sh_op | op_arr[i];
      end
    end
  end

  assign sh_right = sh_op.right;
  assign sh_arith = sh_op.arith;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (pick_any) begin
      rr_ptr_q <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  tag_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (flush[gi]) begin
        valid_q <= 1'b0;
      end else if (grant[gi]) begin
        valid_q <= 1'b1;
        data_q  <= sh_res;
        tag_q   <= tag_arr[gi];
      end else if (resp_ready[gi] && valid_q) begin
        valid_q <= 1'b0;
      end
    end

    assign resp_valid[gi]                   = valid_q;
    assign resp_data[gi*DATA_W +: DATA_W]   = data_q;
    assign resp_tag[gi*TAG_W +: TAG_W]      = tag_q;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural barrel shifter in the loop.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned TAG_W = 4;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*DATA_W-1:0]  req_d;
  logic [NREQ*SHAMT_W-1:0] req_sa;
  logic [NREQ-1:0]         req_right;
  logic [NREQ-1:0]         req_arith;
  logic [NREQ*TAG_W-1:0]   req_tag;
  logic [NREQ-1:0]         flush;
  logic [DATA_W-1:0]       sh_d;
  logic [SHAMT_W-1:0]      sh_sa;
  logic                    sh_right;
  logic                    sh_arith;
  logic [DATA_W-1:0]       sh_res;
  logic [NREQ-1:0]         resp_valid;
  logic [NREQ-1:0]         resp_ready;
  logic [NREQ*DATA_W-1:0]  resp_data;
  logic [NREQ*TAG_W-1:0]   resp_tag;
  logic [IDX_W-1:0]        grant_idx;

  int total = 0;
  int bad   = 0;

  shift_arbiter #(
    .NREQ (NREQ),
    .TAG_W(TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_d     (req_d),
    .req_sa    (req_sa),
    .req_right (req_right),
    .req_arith (req_arith),
    .req_tag   (req_tag),
    .flush     (flush),
    .sh_d      (sh_d),
    .sh_sa     (sh_sa),
    .sh_right  (sh_right),
    .sh_arith  (sh_arith),
    .sh_res    (sh_res),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_tag  (resp_tag),
    .grant_idx (grant_idx)
  );

  // External shifter; arith is ignored on left shifts.
  always_comb begin
    if (!sh_right)     sh_res = sh_d << sh_sa;
    else if (sh_arith) sh_res = $unsigned($signed(sh_d) >>> sh_sa);
    else               sh_res = sh_d >> sh_sa;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [31:0] d, input logic [4:0] sa,
                       input shift_op_t op, input logic [3:0] tag);
    if (i == 0) begin
      req_d[31:0] = d;
      req_sa[4:0] = sa;
      req_right[0] = op.right;
      req_arith[0] = op.arith;
      req_tag[3:0] = tag;
    end else begin
      req_d[63:32] = d;
      req_sa[9:5]  = sa;
      req_right[1] = op.right;
      req_arith[1] = op.arith;
      req_tag[7:4] = tag;
    end
  endtask

  logic [2:0] exp_gnt [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
  logic [1:0] exp_rv  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_d      = '0;
    req_sa     = '0;
    req_right  = '0;
    req_arith  = '0;
    req_tag    = '0;
    flush      = '0;
    resp_ready = '0;
    drive(0, 32'h1234_5678, 5'd3, SHIFT_SRA, 4'h7);
    drive(1, 32'h0000_0055, 5'd1, SHIFT_SLL, 4'h9);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_sh_d", 64'(sh_d), 64'h0);
    chk("rst_sh_ctl", 64'({sh_sa, sh_right, sh_arith}), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_data", resp_data, 64'h0);
    tick();
    tick();
    rst       = 1'b0;
    req_valid = 2'b00;

    // Single SLL
    req_valid = 2'b01;
    drive(0, 32'h0000_0001, 5'd4, SHIFT_SLL, 4'd3);
    #1;
    chk("sll_ready", 64'(req_ready), 64'h1);
    chk("sll_gidx", 64'(grant_idx), 64'h0);
    chk("sll_sh_d", 64'(sh_d), 64'h1);
    chk("sll_sh_sa", 64'(sh_sa), 64'h4);
    tick();
    req_valid = 2'b00;
    chk("sll_rv", 64'(resp_valid), 64'h1);
    chk("sll_data", 64'(resp_data[31:0]), 64'h10);
    chk("sll_tag", 64'(resp_tag[3:0]), 64'h3);

    // SRA then SRL, draining the full slot in the same cycle
    resp_ready = 2'b01;
    req_valid  = 2'b01;
    drive(0, 32'h8000_0000, 5'd4, SHIFT_SRA, 4'd5);
    #1;
    chk("sra_ready", 64'(req_ready), 64'h1);
    tick();
    chk("sra_rv", 64'(resp_valid), 64'h1);
    chk("sra_data", 64'(resp_data[31:0]), 64'hF800_0000);
    chk("sra_tag", 64'(resp_tag[3:0]), 64'h5);
    drive(0, 32'h8000_0000, 5'd4, SHIFT_SRL, 4'd6);
    tick();
    chk("srl_data", 64'(resp_data[31:0]), 64'h0800_0000);
    chk("srl_tag", 64'(resp_tag[3:0]), 64'h6);

    // Arith with left shift passes through as a logical left shift
    drive(0, 32'h0000_000F, 5'd4, '{right: 1'b0, arith: 1'b1}, 4'd7);
    #1;
    chk("lsl_arith_pass", 64'(sh_arith), 64'h1);
    tick();
    chk("lsl_arith_data", 64'(resp_data[31:0]), 64'hF0);

    // sa=0 returns d after one cycle
    drive(0, 32'h1234_5678, 5'd0, SHIFT_SRA, 4'd8);
    tick();
    chk("sa0_data", 64'(resp_data[31:0]), 64'h1234_5678);
    chk("sa0_rv", 64'(resp_valid), 64'h1);

    // Drain everything; pointer now sits at 1
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    tick();
    chk("drain_rv", 64'(resp_valid), 64'h0);

    // Fill both slots, then async reset between edges
    resp_ready = 2'b00;
    req_valid  = 2'b11;
    drive(0, 32'h0000_000A, 5'd0, SHIFT_SLL, 4'd1);
    drive(1, 32'h0000_000B, 5'd0, SHIFT_SLL, 4'd2);
    #1;
    chk("fill_gidx1", 64'(grant_idx), 64'h1);
    tick();
    chk("fill_rv1", 64'(resp_valid), 64'h2);
    chk("fill_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk("fill_rv2", 64'(resp_valid), 64'h3);
    chk("fill_data", resp_data, 64'h0000_000B_0000_000A);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rv", 64'(resp_valid), 64'h0);
    chk("arst_data", resp_data, 64'h0);
    chk("arst_tag", 64'(resp_tag), 64'h0);
    #2;
    rst = 1'b0;
    tick();

    // Contention: grants alternate starting at 0 after reset
    resp_ready = 2'b11;
    req_valid  = 2'b11;
    drive(0, 32'h0000_0001, 5'd1, SHIFT_SLL, 4'd1);
    drive(1, 32'h0000_0001, 5'd2, SHIFT_SLL, 4'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont_gidx%0d", k), 64'(grant_idx), 64'(exp_gnt[k]));
      chk($sformatf("cont_ready%0d", k), 64'(req_ready), (exp_gnt[k] == 3'd0) ? 64'h1 : 64'h2);
      tick();
      chk($sformatf("cont_rv%0d", k), 64'(resp_valid), 64'(exp_rv[k]));
    end
    chk("cont_data", resp_data, 64'h0000_0004_0000_0002);

    // Backpressure on requester 0
    resp_ready = 2'b10;
    #1;
    chk("bp_first0", 64'(req_ready), 64'h1);
    tick();
    chk("bp_fill_rv", 64'(resp_valid), 64'h1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'h2);
      chk($sformatf("bp_gidx%0d", k), 64'(grant_idx), 64'h1);
      tick();
      chk($sformatf("bp_rv%0d", k), 64'(resp_valid), 64'h3);
    end
    resp_ready = 2'b11;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'h1);
    tick();
    chk("bp_release_rv", 64'(resp_valid), 64'h1);

    // Flush requester 1 holding DEADBEEF
    resp_ready = 2'b00;
    req_valid  = 2'b10;
    drive(1, 32'hDEAD_BEEF, 5'd0, SHIFT_SLL, 4'hC);
    tick();
    chk("fl_load_rv", 64'(resp_valid), 64'h3);
    chk("fl_load_data", 64'(resp_data[63:32]), 64'hDEAD_BEEF);
    flush     = 2'b10;
    req_valid = 2'b11;
    #1;
    chk("fl_ready", 64'(req_ready), 64'h0);
    chk("fl_idle_sh_d", 64'(sh_d), 64'h0);
    tick();
    chk("fl_rv", 64'(resp_valid), 64'h1);
    chk("fl_hold_data", 64'(resp_data[63:32]), 64'hDEAD_BEEF);
    flush     = 2'b00;
    req_valid = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
